// File: rtl/debounce_fsm_amisha.sv
// Switch debouncer: four-state FSM with a stability counter, registered level and rise tick.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser ahead of the FSM (adds 2 cycles latency).
module debounce_fsm_amisha #(
    parameter int DB_CYCLES = 10,
    parameter int CNT_W     = 4
) (
    input  logic clk_amisha,
    input  logic reset_n_amisha,
    input  logic sw_amisha,
    output logic db_level_amisha,
    output logic db_tick_amisha
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next;
    logic             tick_next;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sw_amisha};
        end
    end

    assign s = sync_q[1];
`else
    // Raw input is assumed already synchronous to clk_amisha in this build.
    assign s = sw_amisha;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state           <= ZERO;
            cnt             <= '0;
            db_level_amisha <= 1'b0;
            db_tick_amisha  <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            db_level_amisha <= level_next;
            db_tick_amisha  <= tick_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        tick_next  = 1'b0;
        unique case (state)
            ZERO: begin
                if (s) state_next = WAIT1;
            end
            WAIT1: begin
                if (!s) begin
                    state_next = ZERO;
                end else if (cnt == CNT_MAX) begin
                    state_next = ONE;
                    tick_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ONE: begin
                if (!s) state_next = WAIT0;
            end
            WAIT0: begin
                if (s) begin
                    state_next = ONE;
                end else if (cnt == CNT_MAX) begin
                    state_next = ZERO;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ZERO;
        endcase
        // Level tracks the state being entered so the register lines up with the state flops.
        level_next = (state_next == ONE) || (state_next == WAIT0);
    end

endmodule

// File: tb/tb_debounce_fsm_amisha.sv
// Self-checking bench for debounce_fsm_amisha: vector table driven through a latency-aware scoreboard,
// plus hand-written asynchronous reset sequences.
`timescale 1ns/1ps
module tb_debounce_fsm_amisha;

    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk_amisha     = 1'b0;
    logic reset_n_amisha = 1'b0;
    logic sw_amisha      = 1'b0;
    logic db_level_amisha;
    logic db_tick_amisha;

    debounce_fsm_amisha #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_amisha     (clk_amisha),
        .reset_n_amisha (reset_n_amisha),
        .sw_amisha      (sw_amisha),
        .db_level_amisha(db_level_amisha),
        .db_tick_amisha (db_tick_amisha)
    );

    always #50 clk_amisha = ~clk_amisha;

    typedef struct packed {
        logic sw;
        logic lvl;
        logic tick;
    } vec_t;

    typedef struct packed {
        logic lvl;
        logic tick;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   ticks_seen = 0;

    // Independent pulse counter: each one-cycle tick spans exactly one falling edge.
    always @(negedge clk_amisha) begin
        if (reset_n_amisha && db_tick_amisha === 1'b1) ticks_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic sw, input logic lvl, input logic tick, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{sw: sw, lvl: lvl, tick: tick});
    endtask

    // Outputs lag the stimulus by LAT extra edges; seed the queue with the reset-state outputs.
    task automatic prefill();
        sb.delete();
        for (int i = 0; i < LAT; i++) sb.push_back('{lvl: 1'b0, tick: 1'b0});
    endtask

    task automatic step(input string name, input logic sw, input logic lvl, input logic tick);
        exp_t e;
        @(negedge clk_amisha);
        sw_amisha = sw;
        sb.push_back('{lvl: lvl, tick: tick});
        @(posedge clk_amisha);
        #1;
        e = sb.pop_front();
        check({name, "_level"}, 32'(db_level_amisha), 32'(e.lvl));
        check({name, "_tick"},  32'(db_tick_amisha),  32'(e.tick));
    endtask

    initial begin
        // Reset held for 100 ns with sw low: outputs stay low, even across a clock edge.
        #10;
        check("rst_level_early", 32'(db_level_amisha), 32'd0);
        check("rst_tick_early",  32'(db_tick_amisha),  32'd0);
        #85;
        check("rst_level_late", 32'(db_level_amisha), 32'd0);
        check("rst_tick_late",  32'(db_tick_amisha),  32'd0);
        @(negedge clk_amisha);
        reset_n_amisha = 1'b1;
        prefill();

        // Idle
        add(0, 0, 0, 2);
        // Clean 0->1: rise with tick on the 5th edge, tick gone on the 6th
        add(1, 0, 0, 4); add(1, 1, 1, 1); add(1, 1, 0, 2);
        // Clean 1->0: level falls on the 5th edge, no tick
        add(0, 1, 0, 4); add(0, 0, 0, 2);
        // Glitch during WAIT1 restarts the count, single tick afterwards
        add(1, 0, 0, 3); add(0, 0, 0, 1); add(1, 0, 0, 4); add(1, 1, 1, 1); add(1, 1, 0, 2);
        // Glitch during WAIT0 returns to ONE, then a full fall
        add(0, 1, 0, 2); add(1, 1, 0, 1); add(0, 1, 0, 4); add(0, 0, 0, 3);
        // High for exactly DB_CYCLES edges then drop: one edge short of acceptance
        add(1, 0, 0, 4); add(0, 0, 0, 3);

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].sw, vecs[i].lvl, vecs[i].tick);

        // Reset asserted mid-WAIT1 with a partial count
        for (int i = 0; i < 3; i++) step($sformatf("wait1_pre%0d", i), 1'b1, 1'b0, 1'b0);
        #20;
        reset_n_amisha = 1'b0;
        #1;
        check("async_rst_wait1_level", 32'(db_level_amisha), 32'd0);
        check("async_rst_wait1_tick",  32'(db_tick_amisha),  32'd0);
        @(posedge clk_amisha);
        #1;
        check("rst_hold_level", 32'(db_level_amisha), 32'd0);
        check("rst_hold_tick",  32'(db_tick_amisha),  32'd0);
        #1;
        reset_n_amisha = 1'b1;
        prefill();

        // After release with sw held high, a full delay is needed again
        for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i), 1'b1, 1'b0, 1'b0);
        step("post_rst_rise", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step($sformatf("post_rst_hold%0d", i), 1'b1, 1'b1, 1'b0);

        // Reset from ONE clears the level immediately, without a clock edge
        #20;
        reset_n_amisha = 1'b0;
        #1;
        check("async_rst_one_level", 32'(db_level_amisha), 32'd0);
        check("async_rst_one_tick",  32'(db_tick_amisha),  32'd0);
        #10;
        reset_n_amisha = 1'b1;
        sw_amisha      = 1'b0;

        check("tick_pulse_count", 32'(ticks_seen), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
